// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with execute-stage operand selection.
// Captures decoded instructions, resolves ALU operands through MEM/WB
// forwarding, and detects load-use hazards (StallD) that insert a bubble.
// Branch flushes (FlushE) are applied as bubbles too.
module ex_issue_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            D_valid,
  input  logic [XLEN-1:0] D_RD1,
  input  logic [XLEN-1:0] D_RD2,
  input  logic [RA_W-1:0] D_Rs1,
  input  logic [RA_W-1:0] D_Rs2,
  input  logic [RA_W-1:0] D_Rd,
  input  logic [XLEN-1:0] D_ImmExt,
  input  logic [XLEN-1:0] D_PC,
  input  logic [2:0]      D_ALUControl,
  input  logic            D_ALUSrc,
  input  logic            D_RegWrite,
  input  logic            D_MemWrite,
  input  logic            D_Branch,
  input  logic [1:0]      D_ResultSrc,
  input  logic            FlushE,
  input  logic            M_RegWrite,
  input  logic [RA_W-1:0] M_Rd,
  input  logic [XLEN-1:0] M_ALUResult,
  input  logic            W_RegWrite,
  input  logic [RA_W-1:0] W_Rd,
  input  logic [XLEN-1:0] W_Result,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [2:0]      ALUControl,
  output logic [XLEN-1:0] E_WriteData,
  output logic [RA_W-1:0] E_Rd,
  output logic [XLEN-1:0] E_PC,
  output logic [XLEN-1:0] E_ImmExt,
  output logic            E_RegWrite,
  output logic            E_MemWrite,
  output logic            E_Branch,
  output logic            E_valid,
  output logic [1:0]      E_ResultSrc,
  output logic            StallD
);

  // ID/EX state
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q;
  logic [RA_W-1:0] rs1_q, rs2_q, rd_q;
  logic [2:0]      aluctl_q;
  logic            alusrc_q, valid_q, regw_q, memw_q, br_q;
  logic [1:0]      rsrc_q;

  logic            stall_s;
  logic            bubble_s;
  logic [XLEN-1:0] fwd_a_s, fwd_b_s;

  // Select the freshest value of one source register: MEM beats WB,
  // register x0 never forwards, nothing forwards for an empty EX slot.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_valid,
    input logic            m_we,
    input logic [RA_W-1:0] m_rd,
    input logic [XLEN-1:0] m_val,
    input logic            w_we,
    input logic [RA_W-1:0] w_rd,
    input logic [XLEN-1:0] w_val
  );
    logic [XLEN-1:0] r;
    if (FWD_EN && ex_valid && m_we && (m_rd != {RA_W{1'b0}}) && (m_rd == rs)) begin
      r = m_val;
    end else if (FWD_EN && ex_valid && w_we && (w_rd != {RA_W{1'b0}}) && (w_rd == rs)) begin
      r = w_val;
    end else begin
      r = rf_val;
    end
    return r;
  endfunction

  // Load-use detection: a load in EX whose destination is read by decode.
  always_comb begin
    stall_s = valid_q & (rsrc_q == 2'b01) & (rd_q != {RA_W{1'b0}}) & D_valid &
              ((D_Rs1 == rd_q) | (D_Rs2 == rd_q));
  end

  assign bubble_s = FlushE | stall_s | ~D_valid;

  // Resolve both ALU source operands through the forwarding network.
  always_comb begin
    fwd_a_s = fwd_sel(rs1_q, rd1_q, valid_q, M_RegWrite, M_Rd, M_ALUResult,
                      W_RegWrite, W_Rd, W_Result);
    fwd_b_s = fwd_sel(rs2_q, rd2_q, valid_q, M_RegWrite, M_Rd, M_ALUResult,
                      W_RegWrite, W_Rd, W_Result);
  end

  // ID/EX register: data fields always load; control and Rd clear on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q    <= {XLEN{1'b0}};
      rd2_q    <= {XLEN{1'b0}};
      imm_q    <= {XLEN{1'b0}};
      pc_q     <= {XLEN{1'b0}};
      rs1_q    <= {RA_W{1'b0}};
      rs2_q    <= {RA_W{1'b0}};
      rd_q     <= {RA_W{1'b0}};
      aluctl_q <= 3'b000;
      alusrc_q <= 1'b0;
      valid_q  <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      br_q     <= 1'b0;
      rsrc_q   <= 2'b00;
    end else begin
      rd1_q    <= D_RD1;
      rd2_q    <= D_RD2;
      imm_q    <= D_ImmExt;
      pc_q     <= D_PC;
      rs1_q    <= D_Rs1;
      rs2_q    <= D_Rs2;
      aluctl_q <= D_ALUControl;
      alusrc_q <= D_ALUSrc;
      if (bubble_s) begin
        rd_q    <= {RA_W{1'b0}};
        valid_q <= 1'b0;
        regw_q  <= 1'b0;
        memw_q  <= 1'b0;
        br_q    <= 1'b0;
        rsrc_q  <= 2'b00;
      end else begin
        rd_q    <= D_Rd;
        valid_q <= 1'b1;
        regw_q  <= D_RegWrite;
        memw_q  <= D_MemWrite;
        br_q    <= D_Branch;
        rsrc_q  <= D_ResultSrc;
      end
    end
  end

  assign SrcA        = fwd_a_s;
  assign E_WriteData = fwd_b_s;
  assign SrcB        = alusrc_q ? imm_q : fwd_b_s;
  assign ALUControl  = aluctl_q;
  assign E_Rd        = rd_q;
  assign E_PC        = pc_q;
  assign E_ImmExt    = imm_q;
  assign E_RegWrite  = regw_q;
  assign E_MemWrite  = memw_q;
  assign E_Branch    = br_q;
  assign E_valid     = valid_q;
  assign E_ResultSrc = rsrc_q;
  assign StallD      = stall_s;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural
// model of the instruction occupying the EX slot.
module tb_ex_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        D_valid;
  logic [31:0] D_RD1, D_RD2, D_ImmExt, D_PC;
  logic [4:0]  D_Rs1, D_Rs2, D_Rd;
  logic [2:0]  D_ALUControl;
  logic        D_ALUSrc, D_RegWrite, D_MemWrite, D_Branch;
  logic [1:0]  D_ResultSrc;
  logic        FlushE;
  logic        M_RegWrite, W_RegWrite;
  logic [4:0]  M_Rd, W_Rd;
  logic [31:0] M_ALUResult, W_Result;
  logic [31:0] SrcA, SrcB, E_WriteData, E_PC, E_ImmExt;
  logic [2:0]  ALUControl;
  logic [4:0]  E_Rd;
  logic        E_RegWrite, E_MemWrite, E_Branch, E_valid;
  logic [1:0]  E_ResultSrc;
  logic        StallD;

  int total = 0;
  int bad   = 0;

  ex_issue_stage #(.XLEN(32), .RA_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .D_valid(D_valid),
    .D_RD1(D_RD1), .D_RD2(D_RD2), .D_Rs1(D_Rs1), .D_Rs2(D_Rs2), .D_Rd(D_Rd),
    .D_ImmExt(D_ImmExt), .D_PC(D_PC), .D_ALUControl(D_ALUControl),
    .D_ALUSrc(D_ALUSrc), .D_RegWrite(D_RegWrite), .D_MemWrite(D_MemWrite),
    .D_Branch(D_Branch), .D_ResultSrc(D_ResultSrc), .FlushE(FlushE),
    .M_RegWrite(M_RegWrite), .M_Rd(M_Rd), .M_ALUResult(M_ALUResult),
    .W_RegWrite(W_RegWrite), .W_Rd(W_Rd), .W_Result(W_Result),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .E_WriteData(E_WriteData),
    .E_Rd(E_Rd), .E_PC(E_PC), .E_ImmExt(E_ImmExt), .E_RegWrite(E_RegWrite),
    .E_MemWrite(E_MemWrite), .E_Branch(E_Branch), .E_valid(E_valid),
    .E_ResultSrc(E_ResultSrc), .StallD(StallD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction sitting in EX. 'known' says the data fields
  // are defined (after reset or a real capture); after a bubble they are not.
  typedef struct {
    logic        valid;
    logic        known;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  alu;
    logic        alusrc, regw, memw, br;
    logic [1:0]  rsrc;
  } ex_t;

  ex_t mdl;

  function automatic ex_t mdl_reset();
    ex_t r;
    r = '{default: '0};
    r.known = 1'b1;
    return r;
  endfunction

  // Value an instruction in EX must see for register rs.
  function automatic logic [31:0] model_operand(input logic [4:0] rs, input logic [31:0] rf);
    if (mdl.valid && M_RegWrite && M_Rd != 5'd0 && M_Rd == rs) return M_ALUResult;
    if (mdl.valid && W_RegWrite && W_Rd != 5'd0 && W_Rd == rs) return W_Result;
    return rf;
  endfunction

  function automatic logic model_stall();
    return mdl.valid && mdl.rsrc == 2'b01 && mdl.rd != 5'd0 && D_valid &&
           (D_Rs1 == mdl.rd || D_Rs2 == mdl.rd);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every meaningful output against the model.
  task automatic check_all();
    logic [31:0] b;
    chk("E_valid", 32'(E_valid), 32'(mdl.valid));
    chk("E_RegWrite", 32'(E_RegWrite), 32'(mdl.regw));
    chk("E_MemWrite", 32'(E_MemWrite), 32'(mdl.memw));
    chk("E_Branch", 32'(E_Branch), 32'(mdl.br));
    chk("E_ResultSrc", 32'(E_ResultSrc), 32'(mdl.rsrc));
    chk("E_Rd", 32'(E_Rd), 32'(mdl.rd));
    chk("StallD", 32'(StallD), 32'(model_stall()));
    if (mdl.known) begin
      b = model_operand(mdl.rs2, mdl.rd2);
      chk("SrcA", SrcA, model_operand(mdl.rs1, mdl.rd1));
      chk("E_WriteData", E_WriteData, b);
      chk("SrcB", SrcB, mdl.alusrc ? mdl.imm : b);
      chk("ALUControl", 32'(ALUControl), 32'(mdl.alu));
      chk("E_PC", E_PC, mdl.pc);
      chk("E_ImmExt", E_ImmExt, mdl.imm);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  // Called with inputs already driven just after a rising edge.
  task automatic cycle();
    ex_t nxt;
    logic bub;
    @(negedge clk);
    if (!rst_n) mdl = mdl_reset();
    check_all();
    bub = FlushE || model_stall() || !D_valid;
    nxt = mdl;
    if (bub) begin
      nxt.valid = 1'b0; nxt.known = 1'b0; nxt.regw = 1'b0; nxt.memw = 1'b0;
      nxt.br = 1'b0; nxt.rsrc = 2'b00; nxt.rd = 5'd0;
    end else begin
      nxt.valid = 1'b1; nxt.known = 1'b1;
      nxt.rd1 = D_RD1; nxt.rd2 = D_RD2; nxt.imm = D_ImmExt; nxt.pc = D_PC;
      nxt.rs1 = D_Rs1; nxt.rs2 = D_Rs2; nxt.rd = D_Rd; nxt.alu = D_ALUControl;
      nxt.alusrc = D_ALUSrc; nxt.regw = D_RegWrite; nxt.memw = D_MemWrite;
      nxt.br = D_Branch; nxt.rsrc = D_ResultSrc;
    end
    @(posedge clk);
    if (!rst_n) mdl = mdl_reset();
    else mdl = nxt;
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [2:0] alu, input logic asrc,
                       input logic rw, input logic [1:0] rsrc);
    D_valid = v; D_Rs1 = rs1; D_Rs2 = rs2; D_Rd = rd; D_RD1 = rd1; D_RD2 = rd2;
    D_ImmExt = imm; D_PC = $urandom; D_ALUControl = alu; D_ALUSrc = asrc;
    D_RegWrite = rw; D_MemWrite = 1'b0; D_Branch = 1'b0; D_ResultSrc = rsrc;
  endtask

  task automatic randomize_inputs();
    D_valid = ($urandom_range(0, 7) != 0);
    D_RD1 = $urandom; D_RD2 = $urandom; D_ImmExt = $urandom; D_PC = $urandom;
    D_Rs1 = 5'($urandom_range(0, 7)); D_Rs2 = 5'($urandom_range(0, 7));
    D_Rd = 5'($urandom_range(0, 7));
    D_ALUControl = 3'($urandom_range(0, 7));
    D_ALUSrc = 1'($urandom_range(0, 1)); D_RegWrite = 1'($urandom_range(0, 1));
    D_MemWrite = 1'($urandom_range(0, 1)); D_Branch = 1'($urandom_range(0, 1));
    D_ResultSrc = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
    FlushE = ($urandom_range(0, 7) == 0);
    M_RegWrite = 1'($urandom_range(0, 1)); M_Rd = 5'($urandom_range(0, 7));
    M_ALUResult = $urandom;
    W_RegWrite = 1'($urandom_range(0, 1)); W_Rd = 5'($urandom_range(0, 7));
    W_Result = $urandom;
  endtask

  // Directed scenarios, then randomized traffic.
  initial begin
    mdl = mdl_reset();
    rst_n = 1'b0;
    randomize_inputs();
    @(posedge clk); #1;

    // Reset holds everything cleared regardless of inputs.
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      #1;
      chk("rst_E_valid", 32'(E_valid), 32'd0);
      chk("rst_SrcA", SrcA, 32'd0);
      chk("rst_SrcB", SrcB, 32'd0);
      chk("rst_StallD", 32'(StallD), 32'd0);
      cycle();
    end

    // First capture: add x3,x1,x2 with RD1=5, RD2=7.
    FlushE = 1'b0; M_RegWrite = 1'b0; W_RegWrite = 1'b0;
    set_d(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b000, 1'b0, 1'b1, 2'b00);
    rst_n = 1'b1;
    cycle();
    D_valid = 1'b0;
    #1;
    chk("first_SrcA", SrcA, 32'd5);
    chk("first_SrcB", SrcB, 32'd7);
    chk("first_ALUControl", 32'(ALUControl), 32'd0);
    chk("first_E_Rd", 32'(E_Rd), 32'd3);
    chk("first_E_valid", 32'(E_valid), 32'd1);
    chk("model_pin_SrcA", model_operand(mdl.rs1, mdl.rd1), 32'd5);
    cycle();

    // MEM over WB priority on rs1 = x4, registered RD1 = 0x33.
    set_d(1'b1, 5'd4, 5'd9, 5'd10, 32'h33, 32'h44, 32'd0, 3'b001, 1'b0, 1'b1, 2'b00);
    cycle();
    D_valid = 1'b0;
    M_RegWrite = 1'b1; M_Rd = 5'd4; M_ALUResult = 32'h11;
    W_RegWrite = 1'b1; W_Rd = 5'd4; W_Result = 32'h22;
    #1 chk("prio_mem", SrcA, 32'h11);
    chk("model_pin_mem", model_operand(mdl.rs1, mdl.rd1), 32'h11);
    M_RegWrite = 1'b0;
    #1 chk("prio_wb", SrcA, 32'h22);
    W_RegWrite = 1'b0;
    #1 chk("prio_rf", SrcA, 32'h33);
    cycle();

    // x0 never forwards.
    set_d(1'b1, 5'd1, 5'd0, 5'd2, 32'h1, 32'h0, 32'hFFFF_FFF0, 3'b000, 1'b0, 1'b1, 2'b00);
    cycle();
    M_RegWrite = 1'b1; M_Rd = 5'd0; M_ALUResult = 32'hDEAD;
    #1 chk("x0_WriteData", E_WriteData, 32'd0);
    chk("x0_SrcB", SrcB, 32'd0);
    set_d(1'b1, 5'd1, 5'd0, 5'd2, 32'h1, 32'h0, 32'hFFFF_FFF0, 3'b000, 1'b1, 1'b1, 2'b00);
    cycle();
    D_valid = 1'b0;
    #1 chk("x0_imm_SrcB", SrcB, 32'hFFFF_FFF0);
    chk("x0_imm_WriteData", E_WriteData, 32'd0);
    cycle();
    M_RegWrite = 1'b0;

    // Load-use: lw x5 then add x6,x5,x1.
    set_d(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 3'b000, 1'b1, 1'b1, 2'b01);
    cycle();
    set_d(1'b1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h3, 32'h0, 3'b000, 1'b0, 1'b1, 2'b00);
    #1 chk("lu_stall", 32'(StallD), 32'd1);
    cycle();
    #1 chk("lu_bubble_valid", 32'(E_valid), 32'd0);
    chk("lu_stall_drop", 32'(StallD), 32'd0);
    M_RegWrite = 1'b1; M_Rd = 5'd5; M_ALUResult = 32'h55;
    cycle();
    M_RegWrite = 1'b0;
    W_RegWrite = 1'b1; W_Rd = 5'd5; W_Result = 32'h55;
    D_valid = 1'b0;
    #1 chk("lu_add_valid", 32'(E_valid), 32'd1);
    chk("lu_add_SrcA", SrcA, 32'h55);
    chk("lu_add_SrcB", SrcB, 32'h3);
    chk("lu_add_Rd", 32'(E_Rd), 32'd6);
    cycle();
    W_RegWrite = 1'b0;

    // Flush kills the incoming sub.
    set_d(1'b1, 5'd1, 5'd2, 5'd7, 32'h9, 32'h8, 32'h0, 3'b001, 1'b0, 1'b1, 2'b00);
    FlushE = 1'b1;
    cycle();
    FlushE = 1'b0; D_valid = 1'b0;
    #1 chk("flush_valid", 32'(E_valid), 32'd0);
    chk("flush_regwrite", 32'(E_RegWrite), 32'd0);
    chk("flush_rd", 32'(E_Rd), 32'd0);
    cycle();

    // Flush together with a load-use stall: exactly one bubble.
    set_d(1'b1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, 3'b000, 1'b1, 1'b1, 2'b01);
    cycle();
    set_d(1'b1, 5'd5, 5'd1, 5'd6, 32'h0, 32'h3, 32'h0, 3'b000, 1'b0, 1'b1, 2'b00);
    FlushE = 1'b1;
    #1 chk("fs_stall", 32'(StallD), 32'd1);
    cycle();
    FlushE = 1'b0;
    #1 chk("fs_bubble", 32'(E_valid), 32'd0);
    chk("fs_no_stall", 32'(StallD), 32'd0);
    cycle();
    D_valid = 1'b0;
    #1 chk("fs_capture_valid", 32'(E_valid), 32'd1);
    chk("fs_capture_rd", 32'(E_Rd), 32'd6);

    // Asynchronous reset between clock edges clears EX at once.
    W_RegWrite = 1'b1; W_Rd = 5'd5; W_Result = 32'h77;
    #1 rst_n = 1'b0;
    #1 chk("async_valid", 32'(E_valid), 32'd0);
    chk("async_SrcA", SrcA, 32'd0);
    chk("async_SrcB", SrcB, 32'd0);
    chk("async_StallD", 32'(StallD), 32'd0);
    chk("async_Rd", 32'(E_Rd), 32'd0);
    cycle();
    rst_n = 1'b1;
    W_RegWrite = 1'b0;
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline register plus execute-stage operand selection for the 5-stage pipeline.
- Captures decoded instructions, resolves operands through MEM/WB forwarding, and drives SrcA, SrcB and ALUControl straight into the ALU.
- Detects load-use hazards, producing StallD and inserting bubbles.
- Applies branch flushes as bubbles.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- FWD_EN, 1, 1 = forwarding enabled; 0 = always use the registered RD1/RD2 values.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- D_valid  in  1  decode slot holds a real instruction.
- D_RD1, D_RD2  in  XLEN  register-file read data.
- D_Rs1, D_Rs2, D_Rd  in  RA_W  source and destination register addresses.
- D_ImmExt, D_PC  in  XLEN  extended immediate and PC.
- D_ALUControl  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 srl, 101 slt, 110 xor, 111 sll).
- D_ALUSrc  in  1  1 = SrcB takes the immediate.
- D_RegWrite, D_MemWrite, D_Branch  in  1  control bits.
- D_ResultSrc  in  2  result source; 01 = load.
- FlushE  in  1  branch taken; kill the instruction entering EX.
- M_RegWrite  in  1  MEM-stage write enable.
- M_Rd  in  RA_W  MEM-stage destination register.
- M_ALUResult  in  XLEN  MEM-stage ALU result.
- W_RegWrite  in  1  WB-stage write enable.
- W_Rd  in  RA_W  WB-stage destination register.
- W_Result  in  XLEN  WB-stage result.
- SrcA, SrcB  out  XLEN  ALU operands.
- ALUControl  out  3  ALU opcode.
- E_WriteData  out  XLEN  forwarded rs2 value, used as store data.
- E_Rd  out  RA_W  EX-stage destination register.
- E_PC, E_ImmExt  out  XLEN  EX-stage PC and immediate.
- E_RegWrite, E_MemWrite, E_Branch, E_valid  out  1  EX-stage control bits.
- E_ResultSrc  out  2  EX-stage result source.
- StallD  out  1  load-use stall request to IF/ID.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All ID/EX registers clear to 0.
  - E_valid = 0, all E_* control = 0, ALUControl = 000.
  - SrcA = SrcB = 0, StallD = 0.
- Capture: 1-cycle latency. On each rising edge the D_* fields load into the E_* registers unless a bubble is required.
- Bubble condition: FlushE | StallD | !D_valid.
  - A bubble clears E_valid, E_RegWrite, E_MemWrite, E_Branch and E_ResultSrc to 0.
  - Data fields (PC, imm, RD1/RD2, register addresses) may load or hold; they are don't-care while E_valid = 0.
  - E_Rd is forced to 0 on a bubble.
- FlushE and StallD together: a single bubble. No state is lost; IF/ID holds per StallD.
- Forwarding (combinational, per source operand):
  - If FWD_EN, E_valid, M_RegWrite, M_Rd != 0 and M_Rd == E_Rs, use M_ALUResult.
  - Else if FWD_EN, E_valid, W_RegWrite, W_Rd != 0 and W_Rd == E_Rs, use W_Result.
  - Else use the registered RD1/RD2.
  - MEM has priority over WB when both match.
  - x0 never forwards.
- Operand drive:
  - SrcA = forwarded rs1.
  - E_WriteData = forwarded rs2.
  - SrcB = E_ALUSrc ? E_ImmExt : forwarded rs2.
  - ALUControl = registered opcode.
- Load-use hazard (combinational from the E registers and the D inputs):
  - StallD = E_valid & (E_ResultSrc == 01) & (E_Rd != 0) & D_valid & ((D_Rs1 == E_Rd) | (D_Rs2 == E_Rd)).
  - StallD is high for exactly 1 cycle per load-use pair, because the inserted bubble clears E_ResultSrc.
- Reset mid-stream: any in-flight instruction is discarded immediately. The first capture occurs on the first rising edge after rst_n deasserts.
- No arithmetic inside the block. All widths pass through unchanged.

Test Plan:
- Reset: hold rst_n = 0 with random D inputs -> E_valid = 0, SrcA = SrcB = 0, StallD = 0. Deassert rst_n with D = add x3,x1,x2 (RD1 = 5, RD2 = 7) -> next cycle SrcA = 5, SrcB = 7, ALUControl = 000, E_Rd = 3, E_valid = 1.
- MEM/WB priority:
  - EX Rs1 = 4, M_Rd = 4 / M_ALUResult = 0x11, W_Rd = 4 / W_Result = 0x22 -> SrcA = 0x11.
  - Drop M_RegWrite -> SrcA = 0x22.
  - Drop W_RegWrite -> SrcA = registered RD1.
- x0 guard: EX Rs2 = 0, M_Rd = 0, M_RegWrite = 1, M_ALUResult = 0xDEAD -> E_WriteData = registered RD2 (0). With ALUSrc = 1, imm = 0xFFFFFFF0 -> SrcB = 0xFFFFFFF0.
- Load-use: EX holds lw x5 (ResultSrc = 01), D = add x6,x5,x1 -> StallD = 1 for one cycle. Next cycle E_valid = 0 and StallD = 0. Following cycle the add is captured and forwards from WB/MEM correctly.
- Flush: FlushE = 1 with valid D sub -> next cycle E_valid = 0, E_RegWrite = 0, E_Rd = 0. FlushE together with StallD -> single bubble, no double capture.
- Async reset mid-operation: drop rst_n between clock edges while E_valid = 1 -> outputs clear immediately, without waiting for a clk edge.
